// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and op-class helpers
// shared by the ALU command sequencer files.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b1111;
   localparam logic [3:0] OP_SUB  = 4'b1110;
   localparam logic [3:0] OP_INC  = 4'b1101;
   localparam logic [3:0] OP_DEC  = 4'b1100;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_CLC  = 4'b0001;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   function automatic logic is_alu_op(input logic [3:0] op);
      return op[2];
   endfunction

   function automatic logic is_arith_op(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

   function automatic logic is_chain_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: command and result valid/ready channels
// of the ALU sequencer; master = producer/consumer side.
interface alu_seq_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_data;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       res_zero;

   modport master (
      output cmd_valid, cmd_op, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data, res_carry, res_zero
   );

endinterface

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: accumulator, carry and zero registers,
// updated from the ALU in CAPTURE or by local ops at accept.
module alu_seq_flags
   import alu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       apply,
   input  logic [3:0] local_op,
   input  logic [7:0] data,
   input  logic       capture,
   input  logic       cap_arith,
   input  logic [7:0] alu_out,
   input  logic       alu_cout,
   output logic [7:0] acc,
   output logic       carry,
   output logic       zero
);

   // ALU capture has priority; local ops act on the accept edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= 8'h00;
         carry <= 1'b0;
         zero  <= 1'b1;
      end else if (capture) begin
         acc   <= alu_out;
         carry <= cap_arith & alu_cout;
         zero  <= (alu_out == 8'h00);
      end else if (apply) begin
         unique case (1'b1)
            (local_op == OP_LOAD): begin
               acc  <= data;
               zero <= (data == 8'h00);
            end
            (local_op == OP_CLC): carry <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accumulator command sequencer around the ALU.
// Option ALU_SEQ_CARRY_CHAIN_EN feeds carry to cin on ADD/SUB.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_seq_ctrl_if.slave    bus,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic             alu_cin,
   output logic             alu_en,
   output logic [3:0]       alu_opcode,
   input  logic [7:0]       alu_out,
   input  logic             alu_cout,
   output logic [CNT_W-1:0] ops_count
);

   state_t     state;
   state_t     next;
   logic       live;
   logic       take;
   logic       give;
   logic       busy;
   logic       cmd_fire;
   logic       res_fire;
   logic [7:0] b_q;
   logic [3:0] op_q;
   logic [7:0] acc;
   logic       carry;
   logic       zero;

   assign cmd_fire = bus.cmd_valid & take;
   assign res_fire = give & bus.res_ready;

   // state register; live keeps cmd_ready low during reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= next;
         live  <= 1'b1;
      end
   end

   // next-state decode
   always_comb begin
      next = state;
      unique case (state)
         IDLE: begin
            if (cmd_fire)
               next = is_alu_op(bus.cmd_op) ? ISSUE : RESP;
         end
         ISSUE:   next = CAPTURE;
         CAPTURE: next = RESP;
         RESP: begin
            if (bus.res_ready)
               next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   // handshake and ALU enable outputs from state
   always_comb begin
      take = 1'b0;
      give = 1'b0;
      busy = 1'b0;
      unique case (state)
         IDLE:    take = live;
         ISSUE:   busy = 1'b1;
         CAPTURE: busy = 1'b1;
         RESP:    give = 1'b1;
         default: ;
      endcase
   end

   // operand/opcode latch; holds last issued ALU op
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_q  <= 8'h00;
         op_q <= 4'h0;
      end else if (cmd_fire && is_alu_op(bus.cmd_op)) begin
         b_q  <= bus.cmd_data;
         op_q <= bus.cmd_op;
      end
   end

   // completed result handshakes, wrapping
   always_ff @(posedge clk) begin
      if (!rst_n)
         ops_count <= '0;
      else if (res_fire)
         ops_count <= ops_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   alu_seq_flags u_flags (
      .clk       (clk),
      .rst_n     (rst_n),
      .apply     (cmd_fire & ~is_alu_op(bus.cmd_op)),
      .local_op  (bus.cmd_op),
      .data      (bus.cmd_data),
      .capture   (state == CAPTURE),
      .cap_arith (is_arith_op(op_q)),
      .alu_out   (alu_out),
      .alu_cout  (alu_cout),
      .acc       (acc),
      .carry     (carry),
      .zero      (zero)
   );

   assign bus.cmd_ready = take;
   assign bus.res_valid = give;
   assign bus.res_data  = acc;
   assign bus.res_carry = carry;
   assign bus.res_zero  = zero;

   assign alu_a      = acc;
   assign alu_b      = b_q;
   assign alu_en     = busy;
   assign alu_opcode = op_q;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   assign alu_cin = busy & is_chain_op(op_q) & carry;
`else
   assign alu_cin = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus reset, stall
// and counter-wrap sequences for alu_seq_ctrl (CNT_W=4).
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_cin;
   logic       alu_en;
   logic [3:0] alu_opcode;
   logic [7:0] alu_out;
   logic       alu_cout;
   logic [3:0] ops_count;

   int checks = 0;
   int errors = 0;
   logic [3:0] cnt_model = 4'd0;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(.CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_en     (alu_en),
      .alu_opcode (alu_opcode),
      .alu_out    (alu_out),
      .alu_cout   (alu_cout),
      .ops_count  (ops_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external 8-bit ALU model
   always_comb begin
      logic [8:0] t;
      t = 9'd0;
      if (alu_en) begin
         case (alu_opcode)
            OP_ADD: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            OP_SUB: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
            OP_INC: t = {1'b0, alu_a} + 9'd1;
            OP_DEC: t = {1'b0, alu_a} - 9'd1;
            OP_AND: t = {1'b0, alu_a & alu_b};
            OP_OR:  t = {1'b0, alu_a | alu_b};
            OP_NOT: t = {1'b0, ~alu_a};
            OP_XOR: t = {1'b0, alu_a ^ alu_b};
            default: t = 9'd0;
         endcase
      end
      alu_out  = t[7:0];
      alu_cout = t[8];
   end

   typedef struct {
      logic [3:0] op;
      logic [7:0] data;
      logic [7:0] acc;
      logic       c;
      logic       z;
      int         lat;
      logic       cin;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_res_data"},  32'(bus.res_data),  32'h00);
      check({tag, "_res_carry"}, 32'(bus.res_carry), 32'd0);
      check({tag, "_res_zero"},  32'(bus.res_zero),  32'd1);
      check({tag, "_alu_a"},     32'(alu_a),         32'd0);
      check({tag, "_alu_b"},     32'(alu_b),         32'd0);
      check({tag, "_alu_cin"},   32'(alu_cin),       32'd0);
      check({tag, "_alu_en"},    32'(alu_en),        32'd0);
      check({tag, "_alu_op"},    32'(alu_opcode),    32'd0);
      check({tag, "_ops_count"}, 32'(ops_count),     32'd0);
   endtask

   // present a command at a negedge; returns at negedge after accept
   task automatic issue(input logic [3:0] op, input logic [7:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      for (int i = 0; i < 20 && !bus.cmd_ready; i++)
         @(negedge clk);
      check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int lat;
      int en_cnt;
      int rv_cnt;

      vecs[0]  = '{OP_LOAD, 8'h0F, 8'h0F, 1'b0, 1'b0, 1, 1'b0};
      vecs[1]  = '{OP_ADD,  8'h01, 8'h10, 1'b0, 1'b0, 3, 1'b0};
      vecs[2]  = '{OP_LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1, 1'b0};
      vecs[3]  = '{OP_ADD,  8'h01, 8'h00, 1'b1, 1'b1, 3, 1'b0};
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      vecs[4]  = '{OP_ADD,  8'h00, 8'h01, 1'b0, 1'b0, 3, 1'b1};
`else
      vecs[4]  = '{OP_ADD,  8'h00, 8'h00, 1'b0, 1'b1, 3, 1'b0};
`endif
      vecs[5]  = '{OP_LOAD, 8'hA5, 8'hA5, 1'b0, 1'b0, 1, 1'b0};
      vecs[6]  = '{OP_AND,  8'h0F, 8'h05, 1'b0, 1'b0, 3, 1'b0};
      vecs[7]  = '{OP_NOT,  8'h00, 8'hFA, 1'b0, 1'b0, 3, 1'b0};
      vecs[8]  = '{OP_LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0, 1, 1'b0};
      vecs[9]  = '{OP_ADD,  8'h20, 8'h10, 1'b1, 1'b0, 3, 1'b0};
      vecs[10] = '{OP_CLC,  8'h77, 8'h10, 1'b0, 1'b0, 1, 1'b0};
      vecs[11] = '{OP_XOR,  8'hFF, 8'hEF, 1'b0, 1'b0, 3, 1'b0};
      vecs[12] = '{OP_OR,   8'h01, 8'hEF, 1'b0, 1'b0, 3, 1'b0};
      vecs[13] = '{OP_SUB,  8'h0F, 8'hE0, 1'b0, 1'b0, 3, 1'b0};
      vecs[14] = '{OP_DEC,  8'h00, 8'hDF, 1'b0, 1'b0, 3, 1'b0};
      vecs[15] = '{OP_INC,  8'h00, 8'hE0, 1'b0, 1'b0, 3, 1'b0};
      vecs[16] = '{4'b0010, 8'h55, 8'hE0, 1'b0, 1'b0, 1, 1'b0};
      vecs[17] = '{OP_SUB,  8'hF0, 8'hF0, 1'b1, 1'b0, 3, 1'b0};
      vecs[18] = '{OP_LOAD, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b0};
      vecs[19] = '{OP_INC,  8'h00, 8'h01, 1'b0, 1'b0, 3, 1'b0};

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'h0;
      bus.cmd_data  = 8'h00;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst");

      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

      // reset while the ALU result is being captured
      issue(OP_ADD, 8'h05);
      @(negedge clk);
      check("cap_alu_en", 32'(alu_en), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("cap_rst");
      rst_n = 1'b1;
      rv_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.res_valid) rv_cnt++;
      end
      check("cap_rst_no_res", 32'(rv_cnt), 32'd0);
      check("cap_rst_count", 32'(ops_count), 32'd0);

      for (int i = 0; i < 20; i++) begin
         issue(vecs[i].op, vecs[i].data);
         lat    = 1;
         en_cnt = 0;
         while (!bus.res_valid && lat < 10) begin
            if (alu_en) begin
               if (en_cnt == 0) begin
                  check($sformatf("v%0d_alu_b", i),
                        32'(alu_b), 32'(vecs[i].data));
                  check($sformatf("v%0d_alu_op", i),
                        32'(alu_opcode), 32'(vecs[i].op));
                  check($sformatf("v%0d_alu_cin", i),
                        32'(alu_cin), 32'(vecs[i].cin));
               end
               en_cnt++;
            end
            @(negedge clk);
            lat++;
         end
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_en_cycles", i), 32'(en_cnt),
               (vecs[i].lat == 3) ? 32'd2 : 32'd0);
         check($sformatf("v%0d_data", i),
               32'(bus.res_data), 32'(vecs[i].acc));
         check($sformatf("v%0d_carry", i),
               32'(bus.res_carry), 32'(vecs[i].c));
         check($sformatf("v%0d_zero", i),
               32'(bus.res_zero), 32'(vecs[i].z));
         check($sformatf("v%0d_no_ready", i), 32'(bus.cmd_ready), 32'd0);
         bus.res_ready = 1'b1;
         @(negedge clk);
         bus.res_ready = 1'b0;
         cnt_model = cnt_model + 4'd1;
         check($sformatf("v%0d_res_drop", i), 32'(bus.res_valid), 32'd0);
         check($sformatf("v%0d_ready", i), 32'(bus.cmd_ready), 32'd1);
         check($sformatf("v%0d_count", i),
               32'(ops_count), 32'(cnt_model));
         if (i == 15)
            check("count_wrap", 32'(ops_count), 32'd0);
      end

      // back-pressure in RESP with a competing command
      issue(OP_LOAD, 8'h3C);
      check("stall_hold_op", 32'(alu_opcode), 32'(OP_INC));
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_ADD;
      bus.cmd_data  = 8'h11;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall%0d_valid", k), 32'(bus.res_valid), 32'd1);
         check($sformatf("stall%0d_data", k), 32'(bus.res_data), 32'h3C);
         check($sformatf("stall%0d_ready", k), 32'(bus.cmd_ready), 32'd0);
         check($sformatf("stall%0d_en", k), 32'(alu_en), 32'd0);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      cnt_model = cnt_model + 4'd1;
      check("stall_drop", 32'(bus.res_valid), 32'd0);
      check("stall_ready", 32'(bus.cmd_ready), 32'd1);
      check("stall_data", 32'(bus.res_data), 32'h3C);
      check("stall_count", 32'(ops_count), 32'(cnt_model));
      repeat (2) @(negedge clk);
      check("stall_no_phantom", 32'(bus.res_valid), 32'd0);
      check("stall_idle_en", 32'(alu_en), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
